task_conflict_checker: RTL and testbench

Locale conflict checker that sits directly downstream of the per-task-type dequeue FIFO. It samples the FIFO head and checks its locale against the locales of tasks currently running on this type's cores. It then either dispatches the task to a free core and answers "accept", or answers "reject" so the FIFO re-enqueues the head at its tail. It tracks core occupancy until each core reports completion.

---
 rtl/task_conflict_checker.sv | 170 +++++++++++++++++
 tb/tb_task_conflict_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/task_conflict_checker.sv
// Purpose: locale conflict checker between a task-type dequeue FIFO head and its cores.
// Latency: head sampled in IDLE -> CHECK next cycle -> accept strobe after the dispatch handshake, reject strobe one cycle after CHECK.
// Backpressure: m_valid and its payload stay fixed until m_ready; the FIFO head is answered only after the dispatch completes.

package tcc_pkg;
  typedef struct packed {
    logic [7:0]  locale;
    logic [23:0] payload;
  } task_t;

  typedef logic [5:0] cq_slice_slot_t;
endpackage

module task_conflict_checker
  import tcc_pkg::*;
#(
  parameter int ID      = 0,
  parameter int N_CORES = 4,
  parameter int BACKOFF = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   s_rvalid,
  input  task_t                                  s_rdata,
  input  cq_slice_slot_t                         s_rslot,
  output logic                                   s_rresp,
  output logic                                   s_rresp_valid,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output task_t                                  m_task,
  output cq_slice_slot_t                         m_slot,
  output logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] m_core,
  input  logic                                   finish_valid,
  input  logic [((N_CORES > 1) ? $clog2(N_CORES) : 1)-1:0] finish_core,
  output logic                                   idle,
  output logic [31:0]                            n_accept,
  output logic [31:0]                            n_reject
);

  localparam int CW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  // Backoff counter runs 0..BACKOFF-1.
  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_DISPATCH, S_ACCEPT, S_REJECT, S_BACKOFF
  } state_e;

  // ID only tags the instance; a negative ID or empty core set elaborates nothing usable.
  if (ID < 0 || N_CORES < 1) begin : g_bad_cfg
  end

  state_e                   state_q, state_d;
  task_t                    task_q, task_d;
  cq_slice_slot_t           slot_q, slot_d;
  logic [CW-1:0]            core_q, core_d;
  logic [N_CORES-1:0]       vld_q, vld_d;
  logic [N_CORES-1:0][7:0]  loc_q, loc_d;
  logic [BW-1:0]            bo_q, bo_d;
  logic [31:0]              acc_q, acc_d;
  logic [31:0]              rej_q, rej_d;

  logic                     conflict;
  logic                     free;
  logic [CW-1:0]            free_idx;

  // Scan the active table against the held locale; downward loop leaves the lowest free index.
  always_comb begin
    conflict = 1'b0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (vld_q[i] && (loc_q[i] == task_q.locale)) conflict = 1'b1;
      if (!vld_q[i]) begin
        free     = 1'b1;
        free_idx = CW'(i);
      end
    end
  end

  // Next-state, table maintenance and counters. A claim only ever hits an invalid entry,
  // so it never collides with a finish in the same cycle.
  always_comb begin
    state_d = state_q;
    task_d  = task_q;
    slot_d  = slot_q;
    core_d  = core_q;
    vld_d   = vld_q;
    loc_d   = loc_q;
    bo_d    = bo_q;
    acc_d   = acc_q;
    rej_d   = rej_q;

    if (finish_valid && (int'(finish_core) < N_CORES)) vld_d[finish_core] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_rvalid) begin
          task_d  = s_rdata;
          slot_d  = s_rslot;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (conflict || !free) begin
          state_d = S_REJECT;
        end else begin
          core_d  = free_idx;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (m_ready) begin
          vld_d[core_q] = 1'b1;
          loc_d[core_q] = task_q.locale;
          state_d       = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        acc_d   = acc_q + 32'd1;
        state_d = S_IDLE;
      end
      S_REJECT: begin
        rej_d   = rej_q + 32'd1;
        bo_d    = '0;
        state_d = (BACKOFF == 0) ? S_IDLE : S_BACKOFF;
      end
      S_BACKOFF: begin
        if (bo_q == BW'(BACKOFF - 1)) state_d = S_IDLE;
        else                          bo_d    = bo_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset discards any held task without responding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      task_q  <= '0;
      slot_q  <= '0;
      core_q  <= '0;
      vld_q   <= '0;
      loc_q   <= '0;
      bo_q    <= '0;
      acc_q   <= '0;
      rej_q   <= '0;
    end else begin
      state_q <= state_d;
      task_q  <= task_d;
      slot_q  <= slot_d;
      core_q  <= core_d;
      vld_q   <= vld_d;
      loc_q   <= loc_d;
      bo_q    <= bo_d;
      acc_q   <= acc_d;
      rej_q   <= rej_d;
    end
  end

  assign m_valid       = (state_q == S_DISPATCH);
  assign m_task        = task_q;
  assign m_slot        = slot_q;
  assign m_core        = core_q;
  assign s_rresp_valid = (state_q == S_ACCEPT) || (state_q == S_REJECT);
  assign s_rresp       = (state_q == S_REJECT);
  assign idle          = (state_q == S_IDLE) && !(|vld_q);
  assign n_accept      = acc_q;
  assign n_reject      = rej_q;

endmodule

// File: tb/tb_task_conflict_checker.sv
// Bench for task_conflict_checker: directed scenarios then random traffic against a
// transaction-level model (busy/locale per core, lowest free core, fixed response timing).
module tb_task_conflict_checker;
  import tcc_pkg::*;

  localparam int NC = 4;
  localparam int BO = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_rvalid;
  task_t          s_rdata;
  cq_slice_slot_t s_rslot;
  logic           s_rresp, s_rresp_valid;
  logic           m_valid, m_ready;
  task_t          m_task;
  cq_slice_slot_t m_slot;
  logic [1:0]     m_core;
  logic           finish_valid;
  logic [1:0]     finish_core;
  logic           idle;
  logic [31:0]    n_accept, n_reject;

  task_conflict_checker #(.ID(0), .N_CORES(NC), .BACKOFF(BO)) dut (
    .clk(clk), .rst(rst),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rslot(s_rslot),
    .s_rresp(s_rresp), .s_rresp_valid(s_rresp_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_task(m_task), .m_slot(m_slot), .m_core(m_core),
    .finish_valid(finish_valid), .finish_core(finish_core),
    .idle(idle), .n_accept(n_accept), .n_reject(n_reject)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state
  bit         busy[NC];
  logic [7:0] bloc[NC];
  int         exp_acc = 0;
  int         exp_rej = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_empty();
    for (int i = 0; i < NC; i++) if (busy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fin(input int c);
    finish_valid = 1'b1;
    finish_core  = 2'(c);
    step();
    finish_valid = 1'b0;
    busy[c] = 1'b0;
  endtask

  // One head presented in IDLE; rd = cycles m_ready is held low in DISPATCH;
  // fin_bo >= 0 issues a finish on that core at the start of the backoff window.
  task automatic txn(input logic [7:0] loc, input int rd, input int fin_bo);
    task_t          t;
    cq_slice_slot_t sl;
    bit             acc;
    int             core;
    acc  = 1'b1;
    core = -1;
    t.locale  = loc;
    t.payload = 24'($urandom);
    sl        = 6'($urandom);
    for (int i = 0; i < NC; i++) begin
      if (busy[i] && bloc[i] == loc) acc = 1'b0;
      if (!busy[i] && core < 0) core = i;
    end
    if (core < 0) acc = 1'b0;

    s_rdata  = t;
    s_rslot  = sl;
    s_rvalid = 1'b1;
    step();
    chk("check_mvalid", 32'(m_valid), 0);
    chk("check_strobe", 32'(s_rresp_valid), 0);
    chk("check_idle", 32'(idle), 0);
    step();
    if (acc) begin
      chk("disp_mvalid", 32'(m_valid), 1);
      chk("disp_core", 32'(m_core), core);
      chk("disp_task", m_task, t);
      chk("disp_slot", 32'(m_slot), 32'(sl));
      chk("disp_strobe", 32'(s_rresp_valid), 0);
      for (int k = 0; k < rd; k++) begin
        step();
        chk("hold_mvalid", 32'(m_valid), 1);
        chk("hold_task", m_task, t);
        chk("hold_core", 32'(m_core), core);
        chk("hold_strobe", 32'(s_rresp_valid), 0);
      end
      m_ready = 1'b1;
      step();
      m_ready  = 1'b0;
      s_rvalid = 1'b0;
      chk("acc_strobe", 32'(s_rresp_valid), 1);
      chk("acc_resp", 32'(s_rresp), 0);
      chk("acc_mvalid", 32'(m_valid), 0);
      busy[core] = 1'b1;
      bloc[core] = loc;
      exp_acc++;
      step();
      chk("acc_strobe_end", 32'(s_rresp_valid), 0);
      chk("n_accept", n_accept, exp_acc);
    end else begin
      chk("rej_strobe", 32'(s_rresp_valid), 1);
      chk("rej_resp", 32'(s_rresp), 1);
      chk("rej_mvalid", 32'(m_valid), 0);
      s_rvalid = 1'b0;
      exp_rej++;
      for (int b = 0; b < BO; b++) begin
        if (b == 0 && fin_bo >= 0) begin
          finish_valid = 1'b1;
          finish_core  = 2'(fin_bo);
        end
        step();
        finish_valid = 1'b0;
        chk("bo_strobe", 32'(s_rresp_valid), 0);
        chk("bo_resp", 32'(s_rresp), 0);
        chk("bo_mvalid", 32'(m_valid), 0);
      end
      if (fin_bo >= 0) busy[fin_bo] = 1'b0;
      step();
      chk("n_reject", n_reject, exp_rej);
    end
    chk("idle_after", 32'(idle), 32'(model_empty()));
  endtask

  initial begin
    rst = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rslot = '0;
    m_ready = 1'b0; finish_valid = 1'b0; finish_core = '0;
    for (int i = 0; i < NC; i++) begin busy[i] = 1'b0; bloc[i] = '0; end
    step();
    step();
    rst = 1'b0;
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_strobe", 32'(s_rresp_valid), 0);
    chk("rst_resp", 32'(s_rresp), 0);
    chk("rst_idle", 32'(idle), 1);
    chk("rst_core", 32'(m_core), 0);
    chk("rst_nacc", n_accept, 0);
    chk("rst_nrej", n_reject, 0);

    // Directed scenarios
    txn(8'h10, 0, -1);       // accept on core 0
    txn(8'h10, 0, -1);       // locale conflict -> reject + backoff
    fin(0);
    txn(8'h0A, 0, -1);
    txn(8'h0B, 0, -1);
    txn(8'h0C, 0, -1);       // core 2
    fin(1);
    txn(8'h0D, 0, -1);       // core 1 reused
    txn(8'h0E, 0, -1);       // core 3, table full
    txn(8'h99, 0, 2);        // full -> reject, core 2 frees during backoff
    txn(8'h99, 0, -1);       // accepted on core 2
    fin(3);
    fin(3);                  // finish on an invalid entry is ignored
    txn(8'h21, 5, -1);       // m_ready held low for 5 cycles

    // Reset while in DISPATCH
    fin(0);
    s_rdata  = '{locale: 8'h77, payload: 24'h123456};
    s_rslot  = 6'h2A;
    s_rvalid = 1'b1;
    step();
    step();
    chk("rstd_pre_mvalid", 32'(m_valid), 1);
    rst      = 1'b1;
    s_rvalid = 1'b0;
    step();
    rst = 1'b0;
    chk("rstd_mvalid", 32'(m_valid), 0);
    chk("rstd_strobe", 32'(s_rresp_valid), 0);
    chk("rstd_idle", 32'(idle), 1);
    chk("rstd_nacc", n_accept, 0);
    for (int i = 0; i < NC; i++) busy[i] = 1'b0;
    exp_acc = 0;
    exp_rej = 0;
    step();
    chk("rstd_no_resp", 32'(s_rresp_valid), 0);
    chk("rstd_idle2", 32'(idle), 1);
    txn(8'h10, 0, -1);       // cleared table: core 0 again

    // Random traffic
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 99) < 45) fin(int'($urandom_range(0, NC - 1)));
      if ($urandom_range(0, 3) == 0) step();
      txn(8'(8'h10 + $urandom_range(0, 5)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NC - 1)) : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
